// File: rtl/writeback_stage_pkg.sv
// Shared CPU encodings: result-select codes, load funct3 values, writeback FSM states.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_CSR  = 2'b11
    } sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_e;

    // Fields of the instruction that must survive a load wait.
    typedef struct packed {
        logic       rd_en;
        logic [4:0] rd_addr;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } ld_ctx_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load extraction: picks byte/half/word from an aligned memory word.
module load_align
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = addr_lo_i[1] ? (addr_lo_i[0] ? data_i[31:24] : data_i[23:16])
                                   : (addr_lo_i[0] ? data_i[15:8]  : data_i[7:0]);
    assign half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        data_o = data_i;
        err_o  = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'b0, byte_sel};
            F3_LH: begin
                data_o = {{16{half_sel[15]}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o = {16'b0, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LW:   err_o = |addr_lo_i;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result select, load completion with wait state, retire counter.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_valid,
    input  logic        i_rd_en,
    input  logic [4:0]  i_rd_addr,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_csr_dat,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_dat,
    output logic        o_we,
    output logic [4:0]  o_addr_wr,
    output logic [31:0] o_dat_wr,
    output logic        o_stall,
    output logic        o_ld_err,
    output logic [63:0] o_instret
);

    state_e      state_q;
    ld_ctx_t     ctx_q, ctx_d;
    logic        we_q, err_q;
    logic [4:0]  addr_q;
    logic [31:0] dat_q;
    logic [63:0] instret_q;

    logic [31:0] res_d, wdat_d, la_data;
    logic        la_err, is_load, retire_d, wr_d;

    // While waiting, extraction runs on the captured fields, not the live inputs.
    always_comb begin
        ctx_d = '{rd_en: i_rd_en, rd_addr: i_rd_addr, funct3: i_ld_funct3, addr_lo: i_ld_addr_lo};
        if (state_q == ST_WAIT_LOAD) ctx_d = ctx_q;
    end

    load_align u_load_align (
        .funct3_i  (ctx_d.funct3),
        .addr_lo_i (ctx_d.addr_lo),
        .data_i    (i_mem_dat),
        .data_o    (la_data),
        .err_o     (la_err)
    );

    always_comb begin
        case (sel_e'(i_sel))
            SEL_PC4: res_d = i_pc4;
            SEL_CSR: res_d = i_csr_dat;
            default: res_d = i_alu_res;
        endcase
    end

    assign is_load  = sel_e'(i_sel) == SEL_LOAD;
    assign retire_d = (state_q == ST_IDLE && i_valid && (!is_load || (!la_err && i_mem_ack)))
                   || (state_q == ST_WAIT_LOAD && i_mem_ack);
    assign wdat_d   = (state_q == ST_WAIT_LOAD || is_load) ? la_data : res_d;
    assign wr_d     = retire_d && ctx_d.rd_en && (ctx_d.rd_addr != 5'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ctx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else if (i_ce) begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid && is_load) begin
                        if (la_err)
                            err_q <= 1'b1;
                        else if (!i_mem_ack) begin
                            state_q <= ST_WAIT_LOAD;
                            ctx_q   <= ctx_d;
                        end
                    end
                end
                ST_WAIT_LOAD: if (i_mem_ack) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            if (retire_d) instret_q <= instret_q + 64'd1;
            // Address/data only move on a real write so they hold otherwise.
            if (wr_d) begin
                we_q   <= 1'b1;
                addr_q <= ctx_d.rd_addr;
                dat_q  <= wdat_d;
            end
        end
    end

    assign o_we      = we_q;
    assign o_addr_wr = addr_q;
    assign o_dat_wr  = dat_q;
    assign o_stall   = (state_q == ST_WAIT_LOAD);
    assign o_ld_err  = err_q;
    assign o_instret = instret_q;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have i_clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have i_rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have i_ce, input, 1, clock enable; when low, all state and outputs hold.
REQ-004 SHALL have i_valid, input, 1, instruction present from memory stage.
REQ-005 SHALL have i_rd_en, input, 1, instruction writes rd; and i_rd_addr, input, 5, destination register.
REQ-006 SHALL have i_sel, input, 2, result source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-007 SHALL have i_alu_res, i_pc4, i_csr_dat, inputs, 32 each, candidate results.
REQ-008 SHALL have i_ld_funct3, input, 3, load type; and i_ld_addr_lo, input, 2, load byte offset.
REQ-009 SHALL have i_mem_ack, input, 1, load data valid; and i_mem_dat, input, 32, raw aligned memory word.
REQ-010 SHALL have o_we, o_addr_wr (5), o_dat_wr (32), outputs, register-file write port.
REQ-011 SHALL have o_stall, output, 1, upstream must hold its instruction.
REQ-012 SHALL have o_ld_err, output, 1, one-cycle pulse on misaligned or illegal load.
REQ-013 SHALL have o_instret, output, 64, retired-instruction count.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT_LOAD; o_stall SHALL be 1 exactly when state is WAIT_LOAD (registered, no combinational path from inputs).
REQ-015 In IDLE with i_valid and i_sel != 01: next cycle o_we = i_rd_en && i_rd_addr != 0, o_addr_wr = i_rd_addr, o_dat_wr = selected source (latency 1).
REQ-016 In IDLE with i_valid, i_sel = 01, legal aligned load, i_mem_ack = 1: write extracted data next cycle, stay IDLE.
REQ-017 In IDLE with valid legal load and i_mem_ack = 0: capture rd_en, rd_addr, funct3, addr_lo; go WAIT_LOAD; o_we = 0.
REQ-018 In WAIT_LOAD: ignore i_valid and all instruction inputs; on i_mem_ack extract from captured fields, write next cycle, return to IDLE; without ack remain, o_we = 0.
REQ-019 Extraction: LB 000 / LBU 100 select byte addr_lo, LH 001 / LHU 101 select halfword addr_lo[1], LW 010 whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 Misaligned (halfword with addr_lo[0] = 1, word with addr_lo != 0) or illegal funct3 (011, 110, 111): no write, no WAIT_LOAD, o_ld_err = 1 for the next cycle, no retire.
REQ-021 o_we SHALL be 0 every cycle with no retiring write; o_addr_wr/o_dat_wr hold last values when o_we = 0.
REQ-022 o_instret SHALL increment by 1 one cycle after every retirement (non-load accept or load completion, including rd = x0 and i_rd_en = 0); wraps at 2^64.
REQ-023 i_mem_ack in IDLE without a valid load SHALL be ignored.

Reset
REQ-024 On i_rst (overrides i_ce): state IDLE, o_we 0, o_addr_wr 0, o_dat_wr 0, o_stall 0, o_ld_err 0, o_instret 0.
REQ-025 Reset in WAIT_LOAD SHALL discard the pending load; a later i_mem_ack SHALL not write.

Structure
REQ-026 Result-select codes, funct3 load encodings and FSM state encodings SHALL live in the shared config/define file used by the CPU.
REQ-027 Load extraction SHALL be a combinational sub-module load_align (inputs funct3, addr_lo, data; outputs data, err).

Verification
REQ-028 ALU op rd=5, i_alu_res=0x12345678 -> next cycle o_we=1, o_addr_wr=5, o_dat_wr=0x12345678, o_instret=1.
REQ-029 LB addr_lo=3, mem_dat=0x80FF0000, ack same cycle -> o_dat_wr=0xFFFFFF80, o_stall stays 0.
REQ-030 LHU addr_lo=2, ack 3 cycles late -> o_stall=1 three cycles, then o_we=1, o_dat_wr=0x0000ABCD for mem_dat=0xABCD1234; next instruction accepted after stall drops.
REQ-031 LW addr_lo=1 -> o_ld_err pulse 1 cycle, o_we=0, o_instret unchanged; ALU op rd=0 -> o_we=0, o_instret+1.
REQ-032 LW waiting, i_rst asserted one cycle, then ack -> no write, o_stall=0, o_instret=0.
REQ-033 i_ce=0 during WAIT_LOAD with ack -> state and outputs unchanged.
